// File: rtl/packet_forwarder_pkg.sv
// Shared types and helpers for the packet forwarder: FSM state encoding and
// the last-beat byte-enable computation.
package packet_forwarder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } fwd_state_e;

  // Byte enables for the final beat: rem valid bytes, MSB-first packing.
  function automatic logic [7:0] last_keep(input logic [2:0] rem);
    logic [7:0] keep;
    if (rem == 3'd0) begin
      keep = 8'hFF;
    end else begin
      keep = ~(8'hFF >> rem);
    end
    return keep;
  endfunction

endpackage

// File: rtl/packet_forwarder_skid_fifo.sv
// Two-entry skid FIFO that absorbs read data still in flight from packetmem
// while the downstream stream is stalled. Push and pop may coincide at any
// occupancy; a push into a full FIFO is accepted only alongside a pop.
module fwd_skid_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_entry0;
  logic [WIDTH-1:0] r_entry1;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        if (r_wr_ptr) begin
          r_entry1 <= i_data;
        end else begin
          r_entry0 <= i_data;
        end
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_rd_ptr ? r_entry1 : r_entry0;
  assign o_count = r_count;

endmodule

// File: rtl/packet_forwarder.sv
// Reads a filled packet buffer out of packetmem two words at a time and
// streams it on a 64-bit AXI-Stream master, pulsing forwarder_done once the
// final beat has been accepted.
module packet_forwarder
  import packet_forwarder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready_for_forwarder,
  input  logic [LEN_WIDTH-1:0]  pkt_byte_len,
  output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                  forwarder_rd_en,
  input  logic [63:0]           forwarder_rd_data,
  output logic                  forwarder_done,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(4 * (2 ** ADDR_WIDTH));

  // Number of 8-byte beats needed to carry len bytes.
  function automatic logic [ADDR_WIDTH-1:0] beats_of(input logic [LEN_WIDTH-1:0] len);
    logic [LEN_WIDTH-1:0] rounded;
    rounded = len + LEN_WIDTH'(7);
    return ADDR_WIDTH'(rounded >> 3);
  endfunction

  fwd_state_e            r_state;
  fwd_state_e            w_next_state;
  logic [2:0]            r_rem;
  logic [ADDR_WIDTH-1:0] r_beats;
  logic [ADDR_WIDTH-1:0] r_reads;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_inflight;
  logic                  r_inflight_last;

  logic [LEN_WIDTH-1:0]  w_clamped_len;
  logic [64:0]           w_head;
  logic [1:0]            w_count;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_rd_en;
  logic                  w_rd_last;
  logic [2:0]            w_credit_used;

  fwd_skid_fifo #(.WIDTH(65)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({forwarder_rd_data, r_inflight_last}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_valid   = (w_count != 2'd0);
  assign w_pop     = w_valid && m_axis_tready;
  assign w_rd_last = (r_reads == (r_beats - ADDR_WIDTH'(1)));

  // A slot freed by this cycle's pop is reusable by this cycle's read, since
  // its data lands a cycle later; that is what sustains one beat per cycle.
  assign w_credit_used = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en       = (r_state == ST_STREAM) && (r_reads < r_beats) &&
                         (w_credit_used < 3'd2);

  // Clamp the requested length to the buffer size.
  always_comb begin
    w_clamped_len = pkt_byte_len;
    if (pkt_byte_len > MAX_LEN) begin
      w_clamped_len = MAX_LEN;
    end else begin
      w_clamped_len = pkt_byte_len;
    end
  end

  // Next-state logic: IDLE -> STREAM/DONE on assignment, STREAM -> DONE after the tlast handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ready_for_forwarder) begin
          if (w_clamped_len == '0) begin
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_STREAM;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (w_pop && w_head[0]) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, packet bookkeeping and read-issue counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_rem           <= 3'd0;
      r_beats         <= '0;
      r_reads         <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && w_rd_last;
      if (r_state == ST_IDLE) begin
        r_reads <= '0;
        r_addr  <= '0;
        if (ready_for_forwarder) begin
          r_rem   <= w_clamped_len[2:0];
          r_beats <= beats_of(w_clamped_len);
        end
      end else if (w_rd_en) begin
        r_reads <= r_reads + ADDR_WIDTH'(1);
        // Hold the address on the final read so a full buffer never wraps.
        if (!w_rd_last) begin
          r_addr <= r_addr + ADDR_WIDTH'(2);
        end
      end
    end
  end

  // Stream outputs come straight from the FIFO head; idle outputs are forced to 0.
  always_comb begin
    m_axis_tvalid = w_valid;
    m_axis_tdata  = 64'h0;
    m_axis_tkeep  = 8'h00;
    m_axis_tlast  = 1'b0;
    if (w_valid) begin
      m_axis_tdata = w_head[64:1];
      m_axis_tlast = w_head[0];
      if (w_head[0]) begin
        m_axis_tkeep = last_keep(r_rem);
      end else begin
        m_axis_tkeep = 8'hFF;
      end
    end else begin
      m_axis_tdata = 64'h0;
      m_axis_tlast = 1'b0;
      m_axis_tkeep = 8'h00;
    end
  end

  assign forwarder_rd_en   = w_rd_en;
  assign forwarder_rd_addr = r_addr;
  assign forwarder_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed bench for packet_forwarder: a behavioural packetmem read port,
// a cycle-stepped packet runner that records beats and reads, and checks
// against hand-computed expectations.
module tb_packet_forwarder;

  localparam int AW = 10;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ready_for_forwarder = 1'b0;
  logic [LW-1:0] pkt_byte_len = '0;
  logic [AW-1:0] forwarder_rd_addr;
  logic          forwarder_rd_en;
  logic [63:0]   forwarder_rd_data;
  logic          forwarder_done;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_last[$];
  int          q_cyc[$];
  int          q_addr[$];
  int          n_done;
  int          done_cyc;
  int          stab_errs;
  int          occ_errs;
  int          valid_seen;

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  packet_forwarder #(.ADDR_WIDTH(AW)) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ready_for_forwarder (ready_for_forwarder),
    .pkt_byte_len        (pkt_byte_len),
    .forwarder_rd_addr   (forwarder_rd_addr),
    .forwarder_rd_en     (forwarder_rd_en),
    .forwarder_rd_data   (forwarder_rd_data),
    .forwarder_done      (forwarder_done),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tkeep        (m_axis_tkeep),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready)
  );

  always #5 clk = ~clk;

  // Buffer contents: a distinct word per address.
  function automatic logic [31:0] wd(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // packetmem read port: one-cycle latency, returns {word[a], word[a+1]}.
  always @(posedge clk) begin
    if (forwarder_rd_en) begin
      forwarder_rd_data <= {wd(int'(forwarder_rd_addr)), wd(int'(forwarder_rd_addr) + 1)};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand one packet to the DUT and step cycles until a few cycles after done.
  task automatic run_packet(input int len, input bit use_pat, input int budget);
    bit          sv_stall;
    logic [63:0] sv_d;
    logic [7:0]  sv_k;
    logic        sv_l;
    int          outstanding;
    q_data.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete(); q_addr.delete();
    n_done = 0; done_cyc = -1; stab_errs = 0; occ_errs = 0; valid_seen = 0;
    sv_stall = 1'b0; sv_d = '0; sv_k = '0; sv_l = 1'b0; outstanding = 0;
    ready_for_forwarder = 1'b1;
    pkt_byte_len = LW'(len);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk);
      #1;
      ready_for_forwarder = 1'b0;
      m_axis_tready = use_pat ? pat[cyc % 6] : 1'b1;
      #1;
      if (forwarder_rd_en) begin
        q_addr.push_back(int'(forwarder_rd_addr));
        outstanding++;
      end
      if (sv_stall) begin
        if (!m_axis_tvalid || m_axis_tdata !== sv_d || m_axis_tkeep !== sv_k || m_axis_tlast !== sv_l)
          stab_errs++;
      end
      if (m_axis_tvalid) valid_seen++;
      sv_stall = m_axis_tvalid && !m_axis_tready;
      sv_d = m_axis_tdata; sv_k = m_axis_tkeep; sv_l = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        q_data.push_back(m_axis_tdata);
        q_keep.push_back(m_axis_tkeep);
        q_last.push_back(m_axis_tlast);
        q_cyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > 2) occ_errs++;
      if (forwarder_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    check("done_seen", done_cyc >= 0, 1'b1);
  endtask

  // Compare the recorded stream against the expected packet image.
  task automatic verify_stream(input string t, input int nb, input logic [7:0] lkeep);
    int derr = 0;
    int kerr = 0;
    int lerr = 0;
    int aerr = 0;
    check({t, " beats"}, 64'(q_data.size()), 64'(nb));
    for (int k = 0; k < q_data.size(); k++) begin
      if (q_data[k] !== {wd(2 * k), wd(2 * k + 1)}) derr++;
      if (q_keep[k] !== ((k == nb - 1) ? lkeep : 8'hFF)) kerr++;
      if (q_last[k] !== (k == nb - 1)) lerr++;
    end
    check({t, " reads"}, 64'(q_addr.size()), 64'(nb));
    for (int k = 0; k < q_addr.size(); k++) begin
      if (q_addr[k] != 2 * k) aerr++;
    end
    check({t, " data_errs"}, 64'(derr), 64'd0);
    check({t, " keep_errs"}, 64'(kerr), 64'd0);
    check({t, " last_errs"}, 64'(lerr), 64'd0);
    check({t, " addr_errs"}, 64'(aerr), 64'd0);
    check({t, " done_count"}, 64'(n_done), 64'd1);
    check({t, " stable_errs"}, 64'(stab_errs), 64'd0);
    check({t, " occupancy_errs"}, 64'(occ_errs), 64'd0);
  endtask

  initial begin
    int acc;
    int rst_done;
    bit hit;

    // Reset state.
    #23;
    check("rst tvalid", m_axis_tvalid, 1'b0);
    check("rst tdata", m_axis_tdata, 64'h0);
    check("rst tkeep", m_axis_tkeep, 8'h00);
    check("rst rd_en", forwarder_rd_en, 1'b0);
    check("rst done", forwarder_done, 1'b0);
    rst_n = 1'b1;

    // 1: two full beats, back-to-back, done one cycle after the last.
    run_packet(16, 1'b0, 40);
    verify_stream("t1", 2, 8'hFF);
    if (q_cyc.size() == 2) begin
      check("t1 beat gap", 64'(q_cyc[1] - q_cyc[0]), 64'd1);
      check("t1 done lag", 64'(done_cyc - q_cyc[1]), 64'd1);
    end else begin
      check("t1 beat timing", 64'(q_cyc.size()), 64'd2);
    end

    // 2: partial last beat, 5 valid bytes.
    run_packet(13, 1'b0, 40);
    verify_stream("t2", 2, 8'hF8);

    // 3: empty packet.
    run_packet(0, 1'b0, 20);
    check("t3 valid_seen", 64'(valid_seen), 64'd0);
    check("t3 reads", 64'(q_addr.size()), 64'd0);
    check("t3 done_count", 64'(n_done), 64'd1);
    check("t3 done_cycle", 64'(done_cyc), 64'd0);

    // 4: eight beats under a repeating backpressure pattern.
    run_packet(64, 1'b1, 200);
    verify_stream("t4", 8, 8'hFF);

    // 5: full buffer at one beat per cycle.
    run_packet(4096, 1'b0, 700);
    verify_stream("t5", 512, 8'hFF);
    if (q_addr.size() > 0) check("t5 last addr", 64'(q_addr[$]), 64'd1022);
    if (q_cyc.size() == 512) check("t5 throughput", 64'(q_cyc[511] - q_cyc[0]), 64'd511);

    // Oversize length clamps to the full buffer.
    run_packet(8191, 1'b0, 700);
    verify_stream("clamp", 512, 8'hFF);

    // 6: reset in the middle of a packet, then a fresh packet.
    ready_for_forwarder = 1'b1;
    pkt_byte_len = LW'(64);
    acc = 0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 60 && !hit; cyc++) begin
      @(posedge clk);
      #1;
      ready_for_forwarder = 1'b0;
      m_axis_tready = 1'b1;
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
        acc++;
        if (acc == 3) hit = 1'b1;
      end
    end
    check("t6 reached beat3", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6 rst tvalid", m_axis_tvalid, 1'b0);
    check("t6 rst tdata", m_axis_tdata, 64'h0);
    check("t6 rst tlast", m_axis_tlast, 1'b0);
    check("t6 rst rd_en", forwarder_rd_en, 1'b0);
    check("t6 rst rd_addr", 64'(forwarder_rd_addr), 64'd0);
    rst_done = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (forwarder_done) rst_done++;
    end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(posedge clk);
      #1;
      if (forwarder_done) rst_done++;
    end
    check("t6 no done", 64'(rst_done), 64'd0);
    run_packet(8, 1'b0, 40);
    verify_stream("t6 next", 1, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
